// File: rtl/rssi_meas_ctrl.sv
// RSSI measurement sequencer: clear datapath, discard warm-up strobes, gather samples, report.
// Optional link_ok hysteresis is enabled by defining RSSI_CTRL_HYST_EN.
module rssi_meas_ctrl #(
  parameter int unsigned CLR_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned HYST       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       ben,
  input  logic [7:0] rssi_in,
  input  logic       rssi_vld,
  input  logic [7:0] cfg_warmup,
  input  logic [7:0] cfg_nmeas,
  input  logic [7:0] thr,
  output logic       dp_clr,
  output logic       meas_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rssi_last,
  output logic [7:0] rssi_min,
  output logic [7:0] rssi_max,
  output logic       link_ok
);

  // One shared counter serves CLEAR cycles, WARMUP strobes and the MEASURE timeout.
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);
  localparam int unsigned CLW = $clog2(CLR_CYCLES + 1);
  localparam int unsigned CW0 = (TW > 8) ? TW : 8;
  localparam int unsigned CW  = (CLW > CW0) ? CLW : CW0;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] WARMUP  = 3'd2;
  localparam logic [2:0] MEASURE = 3'd3;
  localparam logic [2:0] REPORT  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    smp_cnt_q, smp_cnt_d;
  logic [7:0]    warm_q, warm_d, nmeas_q, nmeas_d, thr_q, thr_d;
  logic [7:0]    cur_last_q, cur_last_d, cur_min_q, cur_min_d, cur_max_q, cur_max_d;
  logic [7:0]    last_q, min_q, max_q;
  logic          err_q, link_q, link_d;
  logic          rep_go, timed_out;
  logic [7:0]    nmeas_eff;

  assign nmeas_eff = (nmeas_q == 8'd0) ? 8'd1 : nmeas_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    smp_cnt_d  = smp_cnt_q;
    warm_d     = warm_q;
    nmeas_d    = nmeas_q;
    thr_d      = thr_q;
    cur_last_d = cur_last_q;
    cur_min_d  = cur_min_q;
    cur_max_d  = cur_max_q;
    rep_go     = 1'b0;
    timed_out  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CLEAR;
          cnt_d      = '0;
          smp_cnt_d  = 8'd0;
          warm_d     = cfg_warmup;
          nmeas_d    = cfg_nmeas;
          thr_d      = thr;
          cur_last_d = 8'd0;
          cur_min_d  = 8'd0;
          cur_max_d  = 8'd0;
        end
      end
      CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          state_d = WARMUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WARMUP: begin
        if (warm_q == 8'd0) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end else if (ben) begin
          if (cnt_q[7:0] + 8'd1 == warm_q) begin
            state_d = MEASURE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      MEASURE: begin
        // A sample arriving on the timeout cycle wins over the timeout.
        if (rssi_vld) begin
          cnt_d      = '0;
          cur_last_d = rssi_in;
          if (smp_cnt_q == 8'd0 || rssi_in < cur_min_q) cur_min_d = rssi_in;
          if (smp_cnt_q == 8'd0 || rssi_in > cur_max_q) cur_max_d = rssi_in;
          smp_cnt_d = smp_cnt_q + 8'd1;
          if (smp_cnt_d == nmeas_eff) begin
            state_d = REPORT;
            rep_go  = 1'b1;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d   = REPORT;
          rep_go    = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      rep_go  = 1'b0;
    end
  end

  always_comb begin
`ifdef RSSI_CTRL_HYST_EN
    logic [7:0] thr_lo;
    thr_lo = (32'(thr_q) < HYST) ? 8'd0 : thr_q - 8'(HYST);
    if (cur_min_d >= thr_q)     link_d = 1'b1;
    else if (cur_min_d < thr_lo) link_d = 1'b0;
    else                         link_d = link_q;
`else
    link_d = (cur_min_d >= thr_q);
`endif
    if (timed_out) link_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      smp_cnt_q  <= 8'd0;
      warm_q     <= 8'd0;
      nmeas_q    <= 8'd0;
      thr_q      <= 8'd0;
      cur_last_q <= 8'd0;
      cur_min_q  <= 8'd0;
      cur_max_q  <= 8'd0;
      last_q     <= 8'd0;
      min_q      <= 8'd0;
      max_q      <= 8'd0;
      err_q      <= 1'b0;
      link_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      smp_cnt_q  <= smp_cnt_d;
      warm_q     <= warm_d;
      nmeas_q    <= nmeas_d;
      thr_q      <= thr_d;
      cur_last_q <= cur_last_d;
      cur_min_q  <= cur_min_d;
      cur_max_q  <= cur_max_d;
      if (rep_go) begin
        last_q <= cur_last_d;
        min_q  <= cur_min_d;
        max_q  <= cur_max_d;
        err_q  <= timed_out;
        link_q <= link_d;
      end
    end
  end

  assign dp_clr    = (state_q == CLEAR);
  assign meas_en   = (state_q == WARMUP) || (state_q == MEASURE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == REPORT);
  assign err       = err_q;
  assign rssi_last = last_q;
  assign rssi_min  = min_q;
  assign rssi_max  = max_q;
  assign link_ok   = link_q;

endmodule

// File: tb/tb_rssi_meas_ctrl.sv
// Directed bench for rssi_meas_ctrl: scoreboard of expected reports, checked on done.
module tb_rssi_meas_ctrl;

  localparam int HYST = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, ben, rssi_vld;
  logic [7:0] rssi_in, cfg_warmup, cfg_nmeas, thr;
  logic       dp_clr, meas_en, busy, done, err, link_ok;
  logic [7:0] rssi_last, rssi_min, rssi_max;

  always #5 clk = ~clk;

  rssi_meas_ctrl #(.CLR_CYCLES(4), .TIMEOUT(4096), .HYST(HYST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ben(ben),
    .rssi_in(rssi_in), .rssi_vld(rssi_vld), .cfg_warmup(cfg_warmup),
    .cfg_nmeas(cfg_nmeas), .thr(thr), .dp_clr(dp_clr), .meas_en(meas_en),
    .busy(busy), .done(done), .err(err), .rssi_last(rssi_last),
    .rssi_min(rssi_min), .rssi_max(rssi_max), .link_ok(link_ok)
  );

  typedef struct {
    logic [7:0] last, mn, mx;
    logic       err, link;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0, n_fail = 0, done_cnt = 0;
  logic [7:0] m_last, m_min, m_max, m_thr;
  int         m_n;
  logic       m_link = 1'b0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic link_model(input logic [7:0] mn, input logic [7:0] t, input logic prev);
`ifdef RSSI_CTRL_HYST_EN
    int lo;
    lo = (int'(t) < HYST) ? 0 : int'(t) - HYST;
    if (mn >= t) return 1'b1;
    if (int'(mn) < lo) return 1'b0;
    return prev;
`else
    return (mn >= t);
`endif
  endfunction

  // Start a run; walks through CLEAR (checking dp_clr) and optionally WARMUP.
  task automatic start_run(input logic [7:0] w, input logic [7:0] n, input logic [7:0] t,
                           input bit do_warm, input string tag);
    start = 1'b1; cfg_warmup = w; cfg_nmeas = n; thr = t;
    m_thr = t; m_n = 0;
    step();
    start = 1'b0; cfg_warmup = 8'hff; cfg_nmeas = 8'd1; thr = 8'hff;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_dp_clr"}, dp_clr, 1);
      start    = (k == 1);   // ignored while busy
      rssi_vld = 1'b1;       // ignored outside MEASURE
      rssi_in  = 8'd1;
      step();
    end
    start = 1'b0;
    chk({tag, "_dp_clr_end"}, dp_clr, 0);
    chk({tag, "_meas_en"}, meas_en, 1);
    if (do_warm) begin
      if (w == 8'd0) step();
      for (int i = 0; i < int'(w); i++) begin
        ben = 1'b1;
        step();
        ben = 1'b0;
        rssi_vld = 1'b0;
        if (i < int'(w) - 1) step();
      end
    end
    rssi_vld = 1'b0;
  endtask

  task automatic send(input logic [7:0] v, input bit last);
    exp_t e;
    m_last = v;
    if (m_n == 0 || v < m_min) m_min = v;
    if (m_n == 0 || v > m_max) m_max = v;
    m_n++;
    if (last) begin
      m_link = link_model(m_min, m_thr, m_link);
      e = '{last: m_last, mn: m_min, mx: m_max, err: 1'b0, link: m_link};
      sb.push_back(e);
    end
    rssi_in = v; rssi_vld = 1'b1;
    step();
    rssi_vld = 1'b0;
  endtask

  task automatic check_report(input string tag);
    exp_t e;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_last"}, rssi_last, e.last);
      chk({tag, "_min"}, rssi_min, e.mn);
      chk({tag, "_max"}, rssi_max, e.mx);
      chk({tag, "_err"}, err, e.err);
      chk({tag, "_link"}, link_ok, e.link);
    end
    step();
    chk({tag, "_done_off"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int cnt, dc;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ben = 1'b0; rssi_vld = 1'b0;
    rssi_in = 8'd0; cfg_warmup = 8'd0; cfg_nmeas = 8'd0; thr = 8'd0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_outs", {dp_clr, meas_en, done, err, link_ok}, 0);
    chk("rst_vals", {rssi_last, rssi_min, rssi_max}, 0);
    rst_n = 1'b1;
    step();

    // Basic run, link good
    start_run(8'd2, 8'd3, 8'd50, 1'b1, "r1");
    chk("r1_in_meas", meas_en, 1);
    send(8'd60, 1'b0); send(8'd55, 1'b0); send(8'd70, 1'b1);
    check_report("r1");
    chk("r1_one_done", done_cnt, 1);

    // Timeout without any sample
    start_run(8'd0, 8'd3, 8'd10, 1'b1, "to");
    cnt = 0;
    while (done !== 1'b1 && cnt < 5000) begin step(); cnt++; end
    chk("to_cycles", cnt, 4096);
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_link", link_ok, 0);
    m_link = 1'b0;
    step();
    chk("to_done_off", done, 0);

    // Low minimum, err cleared
    start_run(8'd2, 8'd3, 8'd50, 1'b1, "r2");
    send(8'd60, 1'b0); send(8'd40, 1'b0); send(8'd70, 1'b1);
    check_report("r2");

    // Sample on the final timeout cycle is accepted
    start_run(8'd0, 8'd2, 8'd10, 1'b1, "lc");
    repeat (4095) step();
    send(8'd30, 1'b0);
    chk("lc_no_done", done, 0);
    chk("lc_busy", busy, 1);
    send(8'd20, 1'b1);
    check_report("lc");

    // cfg_nmeas = 0 behaves as 1
    start_run(8'd1, 8'd0, 8'd100, 1'b1, "n0");
    send(8'd90, 1'b1);
    check_report("n0");

    // Link decision sequence 60, 48, 45 against thr 50
    start_run(8'd0, 8'd1, 8'd50, 1'b1, "h1"); send(8'd60, 1'b1); check_report("h1");
    start_run(8'd0, 8'd1, 8'd50, 1'b1, "h2"); send(8'd48, 1'b1); check_report("h2");
    start_run(8'd0, 8'd1, 8'd50, 1'b1, "h3"); send(8'd45, 1'b1); check_report("h3");

    // Abort in WARMUP
    dc = done_cnt;
    start_run(8'd3, 8'd1, 8'd50, 1'b0, "ab");
    ben = 1'b1; step(); ben = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_meas_en", meas_en, 0);
    chk("ab_last_kept", rssi_last, 45);
    step();
    chk("ab_no_done", done_cnt, dc);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("ab_start_busy", busy, 0);
    step();
    chk("ab_start_busy2", busy, 0);

    // Reset in MEASURE
    start_run(8'd0, 8'd2, 8'd50, 1'b1, "rs");
    send(8'd77, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rs_async", {busy, meas_en, dp_clr, done, err, link_ok}, 0);
    chk("rs_vals", {rssi_last, rssi_min, rssi_max}, 0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("rs_no_done", done_cnt, dc);
    chk("rs_idle", busy, 0);
    chk("rs_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
